uart_rx_axis: RTL and testbench

UART receiver that deserialises an asynchronous serial line into words and presents them on an AXI-Stream master interface. It is the receive-side counterpart of the existing AXI-Stream-fed UART transmitter and shares its clock, reset and parameter set. A downstream FIFO or consumer attaches to the master port. Flow control is a single-word output register with overrun detection.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_axis_if.sv | 15 +
 rtl/uart_rx_sync.sv | 27 ++
 rtl/uart_rx_axis.sv | 247 ++++++++++++++++++++++++
 tb/tb_uart_rx_axis.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART receive/transmit pair.
//   rx_state_t   - receiver FSM state encoding
//   clks_per_bit - system clocks per line bit; the transmitter prescaler
//                  uses the same function so both directions agree on rate.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    function automatic int unsigned clks_per_bit(input int unsigned clkrate,
                                                 input int unsigned baud);
        return clkrate / baud;
    endfunction

endpackage

// File: rtl/uart_rx_axis_if.sv
// uart_rx_axis_if: AXI-Stream data channel between the UART receiver and
// its consumer.
//   tdata  - received word
//   tvalid - word available (driven by master)
//   tready - consumer accepts word (driven by slave)
interface uart_rx_axis_if #(
    parameter int WORD_LENGTH = 8
) ();
    logic [WORD_LENGTH-1:0] tdata;
    logic                   tvalid;
    logic                   tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchroniser for asynchronous inputs.
//   clk, rstn - system clock, asynchronous active-low reset
//   d         - asynchronous input
//   q         - synchronised output, RESET_VAL while in reset
module uart_rx_sync #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_axis.sv
// uart_rx_axis: UART receiver presenting words on an AXI-Stream master port
// through a single-word output register with overrun detection.
//   clk, rstn   - system clock, asynchronous active-low reset
//   UART_RX     - serial line, idle high, asynchronous to clk
//   m_axis      - AXI-Stream master (tdata/tvalid out, tready in)
//   busy        - high whenever the receiver is not idle
//   frame_err   - one-cycle pulse: stop bit sampled low
//   overrun_err - one-cycle pulse: word finished while output register full
//   parity_err  - one-cycle pulse: even-parity mismatch (0 without parity)
// Build option: define UART_RX_PARITY_EN to expect an even-parity bit
// between the data bits and the stop bit.
//
// state  | meaning
// IDLE   | line idle, waiting for a low level
// START  | timing to mid start bit to reject glitches
// DATA   | sampling data bits mid-bit, LSB first
// PARITY | sampling the parity bit (parity builds only)
// STOP   | sampling the stop bit, commit or flag framing error
// BREAK  | line held low after a framing error, wait for high
module uart_rx_axis
    import uart_pkg::*;
#(
    parameter int unsigned CLKRATE     = 100_000_000,
    parameter int unsigned BAUD        = 115_200,
    parameter int unsigned WORD_LENGTH = 8
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           UART_RX,
    uart_rx_axis_if.master m_axis,
    output logic           busy,
    output logic           frame_err,
    output logic           overrun_err,
    output logic           parity_err
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLKRATE, BAUD);
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int          CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int          IDX_W        = $clog2(WORD_LENGTH + 1);

    // Down-counter reload values; the sample happens when the count hits 0.
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORD_LENGTH - 1);

    if (CLKS_PER_BIT < 4) begin : g_rate_check
        $error("uart_rx_axis: CLKRATE/BAUD must give at least 4 clocks per bit");
    end

    logic rx_s;

    uart_rx_sync #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (UART_RX),
        .q    (rx_s)
    );

    rx_state_t              state, state_n;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic [IDX_W-1:0]       idx, idx_n;
    logic [WORD_LENGTH-1:0] shift, shift_n;
    logic                   tick;
    logic                   stop_ok;
    logic                   frame_bad;
    logic                   commit;

`ifdef UART_RX_PARITY_EN
    logic par, par_n;
    logic par_bad, par_bad_n;
    logic par_fire;
`endif

    assign tick = (cnt == '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
`ifdef UART_RX_PARITY_EN
            par     <= 1'b0;
            par_bad <= 1'b0;
`endif
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shift <= shift_n;
`ifdef UART_RX_PARITY_EN
            par     <= par_n;
            par_bad <= par_bad_n;
`endif
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        idx_n     = idx;
        shift_n   = shift;
        stop_ok   = 1'b0;
        frame_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_n     = par;
        par_bad_n = par_bad;
`endif
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    cnt_n   = HALF_LOAD;
                end
            end
            START: begin
                if (tick) begin
                    if (!rx_s) begin
                        state_n = DATA;
                        cnt_n   = BIT_LOAD;
                        idx_n   = '0;
`ifdef UART_RX_PARITY_EN
                        par_n   = 1'b0;
`endif
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_n = {rx_s, shift[WORD_LENGTH-1:1]};
                    cnt_n   = BIT_LOAD;
`ifdef UART_RX_PARITY_EN
                    par_n   = par ^ rx_s;
`endif
                    if (idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    // Even parity: data bits plus parity bit XOR to zero.
                    par_bad_n = par ^ rx_s;
                    cnt_n     = BIT_LOAD;
                    state_n   = STOP;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (rx_s) begin
                        stop_ok = 1'b1;
                        state_n = IDLE;
                    end else begin
                        frame_bad = 1'b1;
                        state_n   = BREAK;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef UART_RX_PARITY_EN
    assign commit   = stop_ok && !par_bad;
    assign par_fire = (stop_ok || frame_bad) && par_bad;
`else
    assign commit = stop_ok;
`endif

    logic [WORD_LENGTH-1:0] tdata_q;
    logic                   tvalid_q;
    logic                   frame_err_q;
    logic                   overrun_err_q;

    // A commit may replace a word that is handshaking in the same cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tdata_q       <= '0;
            tvalid_q      <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            frame_err_q   <= frame_bad;
            overrun_err_q <= 1'b0;
            if (commit) begin
                if (!tvalid_q || m_axis.tready) begin
                    tdata_q  <= shift;
                    tvalid_q <= 1'b1;
                end else begin
                    overrun_err_q <= 1'b1;
                end
            end else if (tvalid_q && m_axis.tready) begin
                tvalid_q <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic parity_err_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= par_fire;
        end
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign m_axis.tdata  = tdata_q;
    assign m_axis.tvalid = tvalid_q;
    assign busy          = (state != IDLE);
    assign frame_err     = frame_err_q;
    assign overrun_err   = overrun_err_q;

endmodule

// File: tb/tb_uart_rx_axis.sv
// Bench for uart_rx_axis. A full-rate instance (868 clocks per bit) covers
// the absolute latency and glitch timing; a fast instance (16 clocks per
// bit) covers the functional scenarios and a randomized stream.
module tb_uart_rx_axis;

    localparam int CPB   = 16;
    localparam int HALF  = CPB / 2;
    localparam int CPB_F = 868;
    localparam int W     = 8;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    // Start edge (driven on a falling clock edge) to the rising edge that
    // commits the word: 2 sync + half bit + remaining bits + commit register.
    localparam int LAT   = 2 + HALF + (W + 1 + PB) * CPB + 1;
    localparam int LAT_F = 2 + CPB_F / 2 + (W + 1) * CPB_F + 1;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic rx = 1'b1;
    logic rx_f = 1'b1;
    logic busy, fe, ov, pe;
    logic busy_f, fe_f, ov_f, pe_f;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    uart_rx_axis_if #(.WORD_LENGTH(W)) axis ();
    uart_rx_axis_if #(.WORD_LENGTH(W)) axis_f ();

    uart_rx_axis #(
        .CLKRATE     (100_000_000),
        .BAUD        (6_250_000),
        .WORD_LENGTH (W)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .UART_RX     (rx),
        .m_axis      (axis),
        .busy        (busy),
        .frame_err   (fe),
        .overrun_err (ov),
        .parity_err  (pe)
    );

    uart_rx_axis #(
        .CLKRATE     (100_000_000),
        .BAUD        (115_200),
        .WORD_LENGTH (W)
    ) dut_full (
        .clk         (clk),
        .rstn        (rstn),
        .UART_RX     (rx_f),
        .m_axis      (axis_f),
        .busy        (busy_f),
        .frame_err   (fe_f),
        .overrun_err (ov_f),
        .parity_err  (pe_f)
    );

    // Observer for the fast instance, sampling mid-low-phase.
    int unsigned   cyc = 0;
    int            fe_n = 0, ov_n = 0, pe_n = 0;
    logic [W-1:0]  got_q[$];

    always @(negedge clk) begin
        #2;
        cyc++;
        if (axis.tvalid && axis.tready) got_q.push_back(axis.tdata);
        if (fe) fe_n++;
        if (ov) ov_n++;
        if (pe) pe_n++;
    end

    task automatic bit_time(input logic v);
        rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [W-1:0] d, input logic stop_v, input logic par_flip);
        bit_time(1'b0);
        for (int i = 0; i < W; i++) bit_time(d[i]);
        if (PB == 1) bit_time((^d) ^ par_flip);
        bit_time(stop_v);
        rx = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        axis.tready = 1'b1;
        axis_f.tready = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (axis.tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid got=%b exp=0", axis.tvalid); end
        n_checks++;
        if (axis.tdata !== 8'h00) begin n_fail++; $display("FAIL reset_tdata got=%h exp=00", axis.tdata); end
        n_checks++;
        if ({busy, fe, ov, pe} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got=%b exp=0000", {busy, fe, ov, pe}); end
        n_checks++;
        if ({axis_f.tvalid, busy_f} !== 2'b00) begin n_fail++; $display("FAIL reset_full got=%b exp=00", {axis_f.tvalid, busy_f}); end
        rstn = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_latency_full();
        logic [9:0] frame;
        int rise = -1, busy_fall = -1, vld_cnt = 0, errs = 0;
        logic [W-1:0] data = '0;
        frame = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 9000; i++) begin
            @(negedge clk);
            rx_f = (i / CPB_F < 10) ? frame[i / CPB_F] : 1'b1;
            #2;
            if (axis_f.tvalid) begin
                vld_cnt++;
                if (rise < 0) begin rise = i; data = axis_f.tdata; end
            end
            if (rise >= 0 && busy_fall < 0 && !busy_f) busy_fall = i;
            if (fe_f || ov_f || pe_f) errs++;
        end
        @(negedge clk);
        n_checks++;
        if (rise < LAT_F - 1 || rise > LAT_F + 1) begin n_fail++; $display("FAIL a5_latency got=%0d exp=%0d", rise, LAT_F); end
        n_checks++;
        if (data !== 8'hA5) begin n_fail++; $display("FAIL a5_data got=%h exp=a5", data); end
        n_checks++;
        if (vld_cnt !== 1) begin n_fail++; $display("FAIL a5_valid_cycles got=%0d exp=1", vld_cnt); end
        n_checks++;
        if (busy_fall - rise < 0 || busy_fall - rise > 1) begin n_fail++; $display("FAIL a5_busy_fall got=%0d exp=%0d..%0d", busy_fall, rise, rise + 1); end
        n_checks++;
        if (errs !== 0) begin n_fail++; $display("FAIL a5_errors got=%0d exp=0", errs); end
    endtask

    task automatic test_glitch_full();
        int last_busy = -1, vld = 0, errs = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            rx_f = (i < 100) ? 1'b0 : 1'b1;
            #2;
            if (busy_f) last_busy = i;
            if (axis_f.tvalid) vld++;
            if (fe_f || ov_f || pe_f) errs++;
        end
        @(negedge clk);
        n_checks++;
        if (last_busy < 0 || last_busy > 437) begin n_fail++; $display("FAIL glitch_busy last_high=%0d exp=0..437", last_busy); end
        n_checks++;
        if (vld !== 0 || errs !== 0) begin n_fail++; $display("FAIL glitch_output valid=%0d errs=%0d exp=0,0", vld, errs); end
    endtask

    task automatic test_break();
        int fe0 = fe_n, ov0 = ov_n, pe0 = pe_n;
        got_q.delete();
        axis.tready = 1'b1;
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (3) bit_time(1'b0);
        idle(2 * CPB);
        send_frame(8'h5A, 1'b1, 1'b0);
        idle(20);
        n_checks++;
        if (fe_n - fe0 !== 1) begin n_fail++; $display("FAIL break_frame_err got=%0d exp=1", fe_n - fe0); end
        n_checks++;
        if (got_q.size() !== 1) begin n_fail++; $display("FAIL break_word_count got=%0d exp=1", got_q.size()); end
        else begin
            n_checks++;
            if (got_q[0] !== 8'h5A) begin n_fail++; $display("FAIL break_word got=%h exp=5a", got_q[0]); end
        end
        n_checks++;
        if (ov_n - ov0 !== 0 || pe_n - pe0 !== 0) begin n_fail++; $display("FAIL break_other_errs ov=%0d pe=%0d exp=0,0", ov_n - ov0, pe_n - pe0); end
    endtask

    task automatic test_overrun();
        int ov0 = ov_n;
        got_q.delete();
        axis.tready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        idle(10);
        n_checks++;
        if (axis.tvalid !== 1'b1 || axis.tdata !== 8'h11) begin n_fail++; $display("FAIL overrun_hold got=%b/%h exp=1/11", axis.tvalid, axis.tdata); end
        n_checks++;
        if (ov_n - ov0 !== 1) begin n_fail++; $display("FAIL overrun_pulse got=%0d exp=1", ov_n - ov0); end
        n_checks++;
        if (got_q.size() !== 0) begin n_fail++; $display("FAIL overrun_early_xfer got=%0d exp=0", got_q.size()); end
        axis.tready = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (got_q.size() !== 1 || got_q[0] !== 8'h11) begin n_fail++; $display("FAIL overrun_drain count=%0d exp=1 word 11", got_q.size()); end
        n_checks++;
        if (axis.tvalid !== 1'b0) begin n_fail++; $display("FAIL overrun_valid_drop got=%b exp=0", axis.tvalid); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp_w[3];
        int fe0 = fe_n, ov0 = ov_n;
        exp_w[0] = 8'h00; exp_w[1] = 8'hFF; exp_w[2] = 8'h80;
        got_q.delete();
        axis.tready = 1'b1;
        send_frame(8'h00, 1'b1, 1'b0);
        axis.tready = 1'b0;
        send_frame(8'hFF, 1'b1, 1'b0);
        fork
            send_frame(8'h80, 1'b1, 1'b0);
            begin
                // Handshake 0xFF on exactly the edge that commits 0x80.
                repeat (LAT - 1) @(negedge clk);
                axis.tready = 1'b1;
                @(negedge clk);
                axis.tready = 1'b0;
            end
        join
        idle(5);
        n_checks++;
        if (axis.tvalid !== 1'b1 || axis.tdata !== 8'h80) begin n_fail++; $display("FAIL b2b_pending got=%b/%h exp=1/80", axis.tvalid, axis.tdata); end
        axis.tready = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (got_q.size() !== 3) begin n_fail++; $display("FAIL b2b_count got=%0d exp=3", got_q.size()); end
        else begin
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (got_q[k] !== exp_w[k]) begin n_fail++; $display("FAIL b2b_word%0d got=%h exp=%h", k, got_q[k], exp_w[k]); end
            end
        end
        n_checks++;
        if (ov_n - ov0 !== 0 || fe_n - fe0 !== 0) begin n_fail++; $display("FAIL b2b_errors ov=%0d fe=%0d exp=0,0", ov_n - ov0, fe_n - fe0); end
    endtask

    task automatic test_reset_mid();
        got_q.delete();
        axis.tready = 1'b1;
        bit_time(1'b0);
        bit_time(1'b1);
        bit_time(1'b1);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_busy_before got=%b exp=1", busy); end
        rstn = 1'b0;
        #1;
        n_checks++;
        if ({busy, axis.tvalid, fe, ov} !== 4'b0000 || axis.tdata !== 8'h00) begin
            n_fail++; $display("FAIL rst_mid_outputs flags=%b tdata=%h exp=0000/00", {busy, axis.tvalid, fe, ov}, axis.tdata);
        end
        @(negedge clk);
        rx = 1'b1;
        rstn = 1'b1;
        idle(20);
        send_frame(8'h42, 1'b1, 1'b0);
        idle(20);
        n_checks++;
        if (got_q.size() !== 1 || got_q[0] !== 8'h42) begin n_fail++; $display("FAIL rst_mid_next count=%0d exp=1 word 42", got_q.size()); end
    endtask

    task automatic test_random();
        logic [W-1:0] exp_q[$];
        logic [W-1:0] d;
        int fe0 = fe_n, ov0 = ov_n, pe0 = pe_n;
        got_q.delete();
        axis.tready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            d = W'($urandom_range(0, 255));
            exp_q.push_back(d);
            send_frame(d, 1'b1, 1'b0);
            idle($urandom_range(0, 20));
        end
        idle(10);
        n_checks++;
        if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        else begin
            for (int k = 0; k < exp_q.size(); k++) begin
                n_checks++;
                if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL rand_word%0d got=%h exp=%h", k, got_q[k], exp_q[k]); end
            end
        end
        n_checks++;
        if (fe_n - fe0 !== 0 || ov_n - ov0 !== 0 || pe_n - pe0 !== 0) begin
            n_fail++; $display("FAIL rand_errors fe=%0d ov=%0d pe=%0d exp=0,0,0", fe_n - fe0, ov_n - ov0, pe_n - pe0);
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int pe0 = pe_n;
        got_q.delete();
        axis.tready = 1'b1;
        send_frame(8'h07, 1'b1, 1'b1);
        idle(10);
        n_checks++;
        if (pe_n - pe0 !== 1) begin n_fail++; $display("FAIL parity_pulse got=%0d exp=1", pe_n - pe0); end
        n_checks++;
        if (got_q.size() !== 0) begin n_fail++; $display("FAIL parity_discard got=%0d exp=0", got_q.size()); end
        send_frame(8'h07, 1'b1, 1'b0);
        idle(10);
        n_checks++;
        if (got_q.size() !== 1 || got_q[0] !== 8'h07 || pe_n - pe0 !== 1) begin
            n_fail++; $display("FAIL parity_good count=%0d pe=%0d exp=1,1", got_q.size(), pe_n - pe0);
        end
    endtask
`endif

    initial begin
        axis.tready = 1'b1;
        axis_f.tready = 1'b1;
        @(negedge clk);
        test_reset();
        test_latency_full();
        test_glitch_full();
        test_break();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
